// File: rtl/mem_wb_stage.sv
// Data-memory access and writeback stage: latches one instruction from execute,
// runs an optional req/ack memory access, then issues a single-cycle register write.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  wr_reg,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_err,
  output logic [1:0]  err_code
);

  // Handshake: an instruction is accepted on a rising edge where in_valid and
  // in_ready are both high; execute must hold in_valid and its payload until then.
  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] alu_q;
  logic [4:0]  wr_reg_q;
  logic        m2r_q;
  logic        wb_ok_q;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_q      <= '0;
      wr_reg_q   <= '0;
      m2r_q      <= 1'b0;
      wb_ok_q    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_q      <= alu_result;
            wr_reg_q   <= wr_reg;
            m2r_q      <= mem_to_reg;
            wb_ok_q    <= reg_write && (wr_reg != 5'd0);
            dmem_addr  <= alu_result;
            dmem_wdata <= store_data;
            dmem_we    <= mem_write;
            if (mem_read && mem_write) begin
              mem_err <= 1'b1;
              if (!mem_err) err_code <= 2'b11;
              state <= WB;
            end else if ((mem_read || mem_write) && CHECK_ALIGN &&
                         (alu_result[1:0] != 2'b00)) begin
              mem_err <= 1'b1;
              if (!mem_err) err_code <= 2'b01;
              state <= WB;
            end else if (mem_read || mem_write) begin
              cnt      <= '0;
              dmem_req <= 1'b1;
              state    <= ACCESS;
            end else begin
              // No memory access: the writeback pulse follows on the very next cycle.
              wb_en   <= reg_write && (wr_reg != 5'd0);
              wb_addr <= (reg_write && (wr_reg != 5'd0)) ? wr_reg : 5'd0;
              wb_data <= (reg_write && (wr_reg != 5'd0)) ? alu_result : 32'd0;
              state   <= WB;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            wb_en    <= wb_ok_q;
            wb_addr  <= wb_ok_q ? wr_reg_q : 5'd0;
            wb_data  <= wb_ok_q ? (m2r_q ? dmem_rdata : alu_q) : 32'd0;
            state    <= WB;
          end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            // Final permitted cycle without an ack: abandon the access.
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            if (!mem_err) err_code <= 2'b10;
            state    <= WB;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WB: begin
          wb_en   <= 1'b0;
          wb_addr <= '0;
          wb_data <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// instruction stream checked against a rule-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  wr_reg;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];

  mem_wb_stage #(.TIMEOUT_CYCLES(16), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .wr_reg(wr_reg),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_err(mem_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Driver: called at a negedge; leaves the bench at a negedge with the DUT idle.
  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0; wr_reg = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: presents one instruction, answers dmem_req with an ack on the
  // ack_delay-th request cycle (0 = never), and reports what the DUT did.
  task automatic issue(
    input  logic [31:0] a, input logic [31:0] sd, input logic [4:0] wr,
    input  logic mr, input logic mw, input logic m2r, input logic rw,
    input  int ack_delay, input logic [31:0] rd,
    output int busy, output int req_cyc, output int wb_cnt,
    output logic [4:0] wb_a, output logic [31:0] wb_d,
    output logic stable, output logic hung, output logic start_ready
  );
    start_ready = in_ready;
    alu_result = a; store_data = sd; wr_reg = wr; mem_read = mr; mem_write = mw;
    mem_to_reg = m2r; reg_write = rw; in_valid = 1'b1;
    busy = 0; req_cyc = 0; wb_cnt = 0; wb_a = '0; wb_d = '0; stable = 1'b1; hung = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      dmem_ack = 1'b0;
      if (in_ready) begin
        hung = 1'b0;
        break;
      end
      busy++;
      if (wb_en) begin
        wb_cnt++; wb_a = wb_addr; wb_d = wb_data;
      end else if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin
        stable = 1'b0;
      end
      if (dmem_req) begin
        req_cyc++;
        if (dmem_addr !== a || dmem_we !== mw || (mw && dmem_wdata !== sd)) stable = 1'b0;
        if (req_cyc == ack_delay) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
        end
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    if (wb_en !== 1'b0 || wb_data !== 32'd0) stable = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, dmem_req, dmem_we, wb_en, mem_err} !== 5'b10000 ||
        err_code !== 2'b00 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 ||
        wb_addr !== 5'd0 || wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b req=%b we=%b wb_en=%b err=%b code=%b addr=%h wb_data=%h, required ready=1 all others 0",
               in_ready, dmem_req, dmem_we, wb_en, mem_err, err_code, dmem_addr, wb_data);
    end
  endtask

  task automatic test_alu();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h2A, 32'h0, 5'd5, 0, 0, 0, 1, 0, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || busy != 1 || req != 0 || !sr) begin
      errors++;
      $display("FAIL alu_timing: busy=%0d req=%0d hung=%b, required busy=1 req=0", busy, req, hung);
    end
    checks++;
    if (wbn != 1 || wa !== 5'd5 || wd !== 32'h2A || !st) begin
      errors++;
      $display("FAIL alu_wb: pulses=%0d addr=%0d data=%h clean=%b, required 1 pulse addr=5 data=2a", wbn, wa, wd, st);
    end
  endtask

  task automatic test_load();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h100, 32'h0, 5'd8, 1, 0, 1, 1, 3, 32'hDEADBEEF, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || req != 3 || busy != 4 || !st) begin
      errors++;
      $display("FAIL load_access: req_cycles=%0d busy=%0d stable=%b, required req=3 busy=4 stable=1", req, busy, st);
    end
    checks++;
    if (wbn != 1 || wa !== 5'd8 || wd !== 32'hDEADBEEF || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL load_wb: pulses=%0d addr=%0d data=%h err=%b, required 1 pulse addr=8 data=deadbeef err=0", wbn, wa, wd, mem_err);
    end
  endtask

  task automatic test_store();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h204, 32'h1234, 5'd3, 0, 1, 0, 0, 2, 32'h55, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || req != 2 || !st || wbn != 0) begin
      errors++;
      $display("FAIL store: req_cycles=%0d stable=%b pulses=%0d, required req=2 stable=1 pulses=0", req, st, wbn);
    end
  endtask

  task automatic test_misaligned();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h102, 32'h0, 5'd9, 1, 0, 1, 1, 1, 32'h77, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || req != 0 || wbn != 0 || busy != 1 || mem_err !== 1'b1 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL misaligned: req=%0d pulses=%0d busy=%0d err=%b code=%b, required req=0 pulses=0 busy=1 err=1 code=01",
               req, wbn, busy, mem_err, err_code);
    end
    issue(32'h99, 32'h0, 5'd4, 0, 0, 0, 1, 0, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (wbn != 1 || wa !== 5'd4 || wd !== 32'h99 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL after_error_alu: pulses=%0d addr=%0d data=%h code=%b, required 1 pulse addr=4 data=99 code=01", wbn, wa, wd, err_code);
    end
  endtask

  task automatic test_timeout();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h300, 32'h0, 5'd7, 1, 0, 1, 1, 0, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || req != 16 || busy != 17 || wbn != 0 || mem_err !== 1'b1 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL timeout: req=%0d busy=%0d pulses=%0d err=%b code=%b, required req=16 busy=17 pulses=0 err=1 code=10",
               req, busy, wbn, mem_err, err_code);
    end
    // Ack on the final permitted cycle still completes cleanly.
    apply_reset();
    issue(32'h304, 32'h0, 5'd6, 1, 0, 1, 1, 16, 32'hCAFE0001, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || req != 16 || wbn != 1 || wd !== 32'hCAFE0001 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_expiry: req=%0d pulses=%0d data=%h err=%b, required req=16 pulses=1 data=cafe0001 err=0",
               req, wbn, wd, mem_err);
    end
    issue(32'h11, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (hung || wbn != 0 || busy != 1) begin
      errors++;
      $display("FAIL r0_write: pulses=%0d busy=%0d, required pulses=0 busy=1", wbn, busy);
    end
  endtask

  task automatic test_both();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h400, 32'h1, 5'd2, 1, 1, 0, 1, 1, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    issue(32'h401, 32'h0, 5'd2, 1, 0, 1, 1, 1, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (req != 0 || wbn != 0 || mem_err !== 1'b1 || err_code !== 2'b11) begin
      errors++;
      $display("FAIL rw_both_sticky: req=%0d pulses=%0d err=%b code=%b, required req=0 pulses=0 err=1 code=11",
               req, wbn, mem_err, err_code);
    end
  endtask

  task automatic test_reset_access();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    apply_reset();
    issue(32'h1, 32'h0, 5'd1, 1, 0, 0, 1, 1, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    alu_result = 32'h500; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; wr_reg = 5'd12;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_access: req=%b err=%b, required req=1 err=1", dmem_req, mem_err);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || in_ready !== 1'b1 || mem_err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_in_access: req=%b ready=%b err=%b code=%b, required req=0 ready=1 err=0 code=00",
               dmem_req, in_ready, mem_err, err_code);
    end
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || wb_en !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: ready=%b wb_en=%b req=%b, required ready=1 wb_en=0 req=0", in_ready, wb_en, dmem_req);
    end
    issue(32'h66, 32'h0, 5'd13, 0, 0, 0, 1, 0, 32'h0, busy, req, wbn, wa, wd, st, hung, sr);
    checks++;
    if (wbn != 1 || wa !== 5'd13 || wd !== 32'h66) begin
      errors++;
      $display("FAIL post_reset_alu: pulses=%0d addr=%0d data=%h, required 1 pulse addr=13 data=66", wbn, wa, wd);
    end
  endtask

  // Randomized back-to-back stream; the model applies the stage's rules directly.
  task automatic test_back_to_back();
    int busy, req, wbn; logic [4:0] wa; logic [31:0] wd; logic st, hung, sr;
    logic exp_err; logic [1:0] exp_code;
    apply_reset();
    exp_err = 1'b0; exp_code = 2'b00;
    exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      int kind, d, e, exp_req, exp_busy;
      logic [31:0] a, sd, rd; logic [4:0] wr; logic mr, mw, m2r, rw;
      logic [36:0] exp_item;
      kind = $urandom_range(0, 9);
      a = {$urandom_range(0, 32'h3FFF), 2'b00}; sd = $urandom; rd = $urandom;
      wr = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
      mr = (kind >= 4 && kind <= 5) || kind == 8 || kind == 9;
      mw = (kind >= 6 && kind <= 7) || kind == 9;
      m2r = mr && !mw;
      if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      if (mr && mw) e = 3;
      else if ((mr || mw) && a[1:0] != 2'b00) e = 1;
      else if ((mr || mw) && d == 0) e = 2;
      else e = 0;
      exp_req = (!(mr || mw) || e == 1 || e == 3) ? 0 : (e == 2 ? 16 : d);
      exp_busy = exp_req + 1;
      if (e == 0 && rw && wr != 5'd0) exp_q.push_back({wr, m2r ? rd : a});
      if (e != 0 && !exp_err) exp_code = 2'(e);
      if (e != 0) exp_err = 1'b1;
      issue(a, sd, wr, mr, mw, m2r, rw, d, rd, busy, req, wbn, wa, wd, st, hung, sr);
      checks++;
      if (hung || !sr || busy != exp_busy || req != exp_req || !st) begin
        errors++;
        $display("FAIL rand_timing[%0d]: busy=%0d req=%0d hung=%b stable=%b start_ready=%b, required busy=%0d req=%0d",
                 n, busy, req, hung, st, sr, exp_busy, exp_req);
      end
      checks++;
      if (wbn > 1 || (wbn == 1 && exp_q.size() == 0)) begin
        errors++;
        $display("FAIL rand_wb_unexpected[%0d]: pulses=%0d queued=%0d", n, wbn, exp_q.size());
      end else if (wbn == 1) begin
        exp_item = exp_q.pop_front();
        if ({wa, wd} !== exp_item) begin
          errors++;
          $display("FAIL rand_wb_data[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                   n, wa, wd, exp_item[36:32], exp_item[31:0]);
        end
      end
      checks++;
      if (mem_err !== exp_err || err_code !== exp_code) begin
        errors++;
        $display("FAIL rand_err[%0d]: err=%b code=%b, required err=%b code=%b", n, mem_err, err_code, exp_err, exp_code);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_missing_wb: %0d expected writebacks never seen", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_both();
    test_reset_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
